// File: rtl/spi_pkg.sv
// spi_pkg: shared types and constants for the SPI byte engine.
`timescale 1ns/1ps
package spi_pkg;

    localparam int SPI_BYTE_W      = 8;
    localparam int SPI_DIV_DEFAULT = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SHIFT = 3'd2,
        NEXT  = 3'd3,
        CHECK = 3'd4,
        DONE  = 3'd5
    } spi_state_t;

endpackage

// File: rtl/spi_byte_engine_sclk_gen.sv
// sclk_gen: SCLK divider. Counts DIV clk cycles per half-period while enabled,
// toggles sclk at each wrap and flags the wrap as a rise or fall strobe.
// Clearing forces the counter to zero and sclk low (start of every byte).
`timescale 1ns/1ps
module sclk_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic clr_i,
    output logic sclk_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int            CW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          sclk_q, sclk_d;
    logic          wrap;

    // A wrap marks the last clk of a half-period; sclk flips on the next edge.
    assign wrap   = en_i && (cnt_q == CNT_LAST);
    assign rise_o = wrap && !sclk_q;
    assign fall_o = wrap && sclk_q;
    assign sclk_o = sclk_q;

    // Next-state for the divider counter and the sclk level.
    always_comb begin
        cnt_d  = cnt_q;
        sclk_d = sclk_q;
        if (clr_i) begin
            cnt_d  = '0;
            sclk_d = 1'b0;
        end else if (en_i) begin
            if (wrap) begin
                cnt_d  = '0;
                sclk_d = !sclk_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Divider registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

endmodule

// File: rtl/spi_byte_engine.sv
// spi_byte_engine: SPI mode-0 master that sends a burst of bytes, one per
// downstream counter address, pulsing cont_trans after each byte until the
// counter reports trans_ready.
// Build option: SPI_LOOPBACK_EN samples the internal mosi instead of miso.
// Handshake: send is a level request honoured only in IDLE; cont_trans and
// rx_we are single-cycle strobes with no back-pressure; done pulses once.
`timescale 1ns/1ps
module spi_byte_engine
    import spi_pkg::*;
#(
    parameter int N   = 5,
    parameter int DIV = SPI_DIV_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  send,
    input  logic [SPI_BYTE_W-1:0] tx_data,
    input  logic                  trans_ready,
    input  logic                  miso,
    output logic                  sclk,
    output logic                  mosi,
    output logic                  cs_n,
    output logic                  cont_trans,
    output logic [SPI_BYTE_W-1:0] rx_data,
    output logic                  rx_we,
    output logic                  busy,
    output logic                  done,
    output spi_state_t            state_o
);

    localparam int             BCW      = $clog2(SPI_BYTE_W);
    localparam logic [BCW-1:0] BIT_LAST = BCW'(SPI_BYTE_W - 1);

    // Elaboration guards on the parameters.
    if (DIV < 1) begin : g_bad_div
        $error("spi_byte_engine: DIV must be >= 1");
    end
    if (N < 1) begin : g_bad_n
        $error("spi_byte_engine: N must be >= 1");
    end

    spi_state_t state_q, state_d;

    logic [SPI_BYTE_W-1:0] tx_sh_q, tx_sh_d;
    logic [SPI_BYTE_W-1:0] rx_sh_q, rx_sh_d;
    logic [SPI_BYTE_W-1:0] rx_data_q, rx_data_d;
    logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
    logic                  mosi_q, mosi_d;
    logic                  cs_n_q, cs_n_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  ct_q, ct_d;
    logic                  sample_bit;
    logic                  sclk_w, rise, fall;

    sclk_gen #(.DIV(DIV)) u_sclk_gen (
        .clk    (clk),
        .rst    (rst),
        .en_i   (state_q == SHIFT),
        .clr_i  (state_q == LOAD),
        .sclk_o (sclk_w),
        .rise_o (rise),
        .fall_o (fall)
    );

`ifdef SPI_LOOPBACK_EN
    logic unused_miso;
    assign unused_miso = miso;
    assign sample_bit  = mosi_q;
`else
    assign sample_bit  = miso;
`endif

    // Next-state logic: one byte per LOAD..CHECK loop, DONE once the counter is ready.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (send) state_d = LOAD;
            LOAD:    state_d = SHIFT;
            SHIFT:   if (fall && (bit_cnt_q == BIT_LAST)) state_d = NEXT;
            NEXT:    state_d = CHECK;
            CHECK:   state_d = trans_ready ? DONE : LOAD;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next-state: load, shift on sclk edges, and registered status outputs.
    always_comb begin
        tx_sh_d   = tx_sh_q;
        rx_sh_d   = rx_sh_q;
        rx_data_d = rx_data_q;
        bit_cnt_d = bit_cnt_q;
        mosi_d    = mosi_q;

        if (state_q == LOAD) begin
            tx_sh_d   = tx_data;
            mosi_d    = tx_data[SPI_BYTE_W-1];
            bit_cnt_d = '0;
        end
        if (rise) begin
            rx_sh_d = {rx_sh_q[SPI_BYTE_W-2:0], sample_bit};
        end
        if (fall) begin
            tx_sh_d   = {tx_sh_q[SPI_BYTE_W-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q + BCW'(1);
            // After the last bit mosi keeps its final value until the next LOAD.
            if (bit_cnt_q != BIT_LAST) begin
                mosi_d = tx_sh_q[SPI_BYTE_W-2];
            end
        end
        // The last capture precedes the last fall, so rx_sh_q is complete here.
        if (state_d == NEXT) begin
            rx_data_d = rx_sh_q;
        end

        // Status outputs are registered from the next state so they line up with it.
        cs_n_d = !((state_d == LOAD) || (state_d == SHIFT) ||
                   (state_d == NEXT) || (state_d == CHECK));
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
        ct_d   = (state_d == NEXT);
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_sh_q   <= '0;
            rx_sh_q   <= '0;
            rx_data_q <= '0;
            bit_cnt_q <= '0;
            mosi_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ct_q      <= 1'b0;
        end else begin
            tx_sh_q   <= tx_sh_d;
            rx_sh_q   <= rx_sh_d;
            rx_data_q <= rx_data_d;
            bit_cnt_q <= bit_cnt_d;
            mosi_q    <= mosi_d;
            cs_n_q    <= cs_n_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ct_q      <= ct_d;
        end
    end

    assign sclk       = sclk_w;
    assign mosi       = mosi_q;
    assign cs_n       = cs_n_q;
    assign cont_trans = ct_q;
    assign rx_we      = ct_q;
    assign rx_data    = rx_data_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign state_o    = state_q;

endmodule
